// File: rtl/corr_metrics.sv
// Derived window metrics (covariance, dependence, Hamming distance) from correlator counts.
// Optional dependence divider is compiled in only when CORR_METRICS_DEP_EN is defined.
module corr_metrics #(
  parameter int DIV_ITERS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cg,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_countX,
  input  logic [7:0] i_countY,
  input  logic [7:0] i_countIsect,
  input  logic [7:0] i_countSymdiff,
  output logic [7:0] o_cov,
  output logic [7:0] o_dep,
  output logic [7:0] o_ham,
  output logic       o_valid,
  output logic       o_dropped,
  input  logic       i_clearDropped
);

  // state | meaning
  // IDLE  | ready, waiting for a window
  // MUL   | form xy = (X*Y)>>8 and clamped covariance
  // DIV   | restoring divide, one quotient bit per cycle (divider builds only)
  // DONE  | results visible, o_valid pulses
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd3;
`ifdef CORR_METRICS_DEP_EN
  localparam logic [1:0] DIV  = 2'd2;
  localparam int CntW = $clog2(DIV_ITERS + 1);
`endif

  logic [1:0] state;
  logic [7:0] xReg, yReg, isectReg, symdiffReg;
  logic [7:0] xyNext;
  logic [8:0] covDiff;
  logic [7:0] covNext;

  assign o_ready = (state == IDLE);

  assign xyNext  = 8'((16'(xReg) * 16'(yReg)) >> 8);
  assign covDiff = {1'b0, isectReg} - {1'b0, xyNext};

  // Sign bit disagreeing with bit 7 means the difference left [-128, 127].
  always_comb begin
    covNext = {~covDiff[7], covDiff[6:0]};
    if (covDiff[8] != covDiff[7]) covNext = covDiff[8] ? 8'h00 : 8'hFF;
  end

`ifdef CORR_METRICS_DEP_EN
  logic [7:0]      xyReg, covReg, remReg, remNext, depFinal;
  logic [15:0]     quoReg, quoNext;
  logic [8:0]      trial;
  logic            trialGe;
  logic [CntW-1:0] iterCnt;

  always_comb begin
    trial   = {remReg, quoReg[15]};
    trialGe = (trial >= {1'b0, xyReg});
    remNext = trialGe ? 8'(trial - {1'b0, xyReg}) : trial[7:0];
    quoNext = {quoReg[14:0], trialGe};
  end

  // A zero divisor yields an all-ones quotient, so its result is decided from Isect alone.
  always_comb begin
    if (xyReg == 8'h00)        depFinal = (isectReg == 8'h00) ? 8'h00 : 8'hFF;
    else if (|quoNext[15:8])   depFinal = 8'hFF;
    else                       depFinal = quoNext[7:0];
  end
`else
  assign o_dep = 8'h00;
  // DIV_ITERS only shapes the divider; referenced so the parameter stays on the interface.
  if (DIV_ITERS != 16) begin : gDivItersUnused
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      xReg       <= 8'h00;
      yReg       <= 8'h00;
      isectReg   <= 8'h00;
      symdiffReg <= 8'h00;
      o_cov      <= 8'h00;
      o_ham      <= 8'h00;
      o_valid    <= 1'b0;
      o_dropped  <= 1'b0;
`ifdef CORR_METRICS_DEP_EN
      o_dep      <= 8'h00;
      xyReg      <= 8'h00;
      covReg     <= 8'h00;
      remReg     <= 8'h00;
      quoReg     <= 16'h0000;
      iterCnt    <= '0;
`endif
    end else if (i_cg) begin
      o_valid <= 1'b0;
      if (i_valid && (state != IDLE)) o_dropped <= 1'b1;
      else if (i_clearDropped)        o_dropped <= 1'b0;

      case (state)
        IDLE: begin
          if (i_valid) begin
            xReg       <= i_countX;
            yReg       <= i_countY;
            isectReg   <= i_countIsect;
            symdiffReg <= i_countSymdiff;
            state      <= MUL;
          end
        end
        MUL: begin
`ifdef CORR_METRICS_DEP_EN
          xyReg   <= xyNext;
          covReg  <= covNext;
          remReg  <= 8'h00;
          quoReg  <= {1'b0, isectReg, 7'b0};
          iterCnt <= CntW'(DIV_ITERS);
          state   <= DIV;
`else
          o_cov   <= covNext;
          o_ham   <= symdiffReg;
          o_valid <= 1'b1;
          state   <= DONE;
`endif
        end
`ifdef CORR_METRICS_DEP_EN
        DIV: begin
          remReg  <= remNext;
          quoReg  <= quoNext;
          iterCnt <= iterCnt - CntW'(1);
          if (iterCnt == CntW'(1)) begin
            o_cov   <= covReg;
            o_dep   <= depFinal;
            o_ham   <= symdiffReg;
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_metrics.sv
// Self-checking bench for corr_metrics; follows CORR_METRICS_DEP_EN for latency and o_dep.
module tb_corr_metrics;

  logic       i_clk = 1'b0;
  logic       i_rst, i_cg, i_valid, i_clearDropped;
  logic [7:0] i_countX, i_countY, i_countIsect, i_countSymdiff;
  logic       o_ready, o_valid, o_dropped;
  logic [7:0] o_cov, o_dep, o_ham;

  int checks = 0;
  int errors = 0;

`ifdef CORR_METRICS_DEP_EN
  localparam int LAT     = 18;
  localparam int DROP_AT = 5;
  localparam int GATE_AT = 5;
  localparam int RST_AT  = 9;
`else
  localparam int LAT     = 2;
  localparam int DROP_AT = 1;
  localparam int GATE_AT = 1;
  localparam int RST_AT  = 1;
`endif
  localparam int GATE_LEN = 10;
  localparam int BUDGET   = 80;

  corr_metrics #(.DIV_ITERS(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_valid(i_valid), .o_ready(o_ready),
    .i_countX(i_countX), .i_countY(i_countY), .i_countIsect(i_countIsect),
    .i_countSymdiff(i_countSymdiff), .o_cov(o_cov), .o_dep(o_dep), .o_ham(o_ham),
    .o_valid(o_valid), .o_dropped(o_dropped), .i_clearDropped(i_clearDropped)
  );

  always #5 i_clk = ~i_clk;

  // Reference metrics straight from the arithmetic definitions.
  function automatic void model(input int x, input int y, input int is, input int sd,
                                output logic [7:0] c, output logic [7:0] d, output logic [7:0] h);
    int xy, diff, q;
    xy   = (x * y) / 256;
    diff = is - xy;
    if (diff > 127)  diff = 127;
    if (diff < -128) diff = -128;
    c = 8'(diff + 128);
`ifdef CORR_METRICS_DEP_EN
    if (xy == 0) d = (is == 0) ? 8'h00 : 8'hFF;
    else begin
      q = (is * 128) / xy;
      d = (q > 255) ? 8'hFF : 8'(q);
    end
`else
    d = 8'h00;
`endif
    h = 8'(sd);
  endfunction

  task automatic stepN(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic sendWindow(input logic [7:0] x, input logic [7:0] y, input logic [7:0] is, input logic [7:0] sd);
    i_countX = x; i_countY = y; i_countIsect = is; i_countSymdiff = sd;
    i_valid = 1'b1;
    stepN(1);
    i_valid = 1'b0;
  endtask

  task automatic waitValid(input int startCyc, output int cyc, output bit seen);
    cyc = startCyc;
    seen = 1'b0;
    while (cyc < BUDGET) begin
      if (o_valid) begin seen = 1'b1; break; end
      stepN(1);
      cyc++;
    end
  endtask

  task automatic countPulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin stepN(1); if (o_valid) pulses++; end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    stepN(2);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped got %b want 0", o_dropped); end
    checks++; if ({o_cov, o_dep, o_ham} !== 24'h0) begin errors++; $display("FAIL reset_outputs got %h want 000000", {o_cov, o_dep, o_ham}); end
    i_rst = 1'b0;
    stepN(1);
  endtask

  task automatic test_directed;
    logic [7:0] vx[5] = '{8'h80, 8'h80, 8'hFF, 8'h00, 8'h00};
    logic [7:0] vy[5] = '{8'h80, 8'h80, 8'hFF, 8'h50, 8'h50};
    logic [7:0] vi[5] = '{8'h40, 8'h80, 8'h00, 8'h00, 8'h10};
    logic [7:0] vs[5] = '{8'h80, 8'h11, 8'hFE, 8'h50, 8'h40};
    logic [7:0] ec, ed, eh;
    int cyc;
    bit seen;
    for (int k = 0; k < 5; k++) begin
      model(int'(vx[k]), int'(vy[k]), int'(vi[k]), int'(vs[k]), ec, ed, eh);
      sendWindow(vx[k], vy[k], vi[k], vs[k]);
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL dir%0d_busy got %b want 0", k, o_ready); end
      waitValid(1, cyc, seen);
      checks++; if (!seen || cyc != LAT) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", k, cyc, LAT); end
      checks++; if (o_cov !== ec) begin errors++; $display("FAIL dir%0d_cov got %h want %h", k, o_cov, ec); end
      checks++; if (o_dep !== ed) begin errors++; $display("FAIL dir%0d_dep got %h want %h", k, o_dep, ed); end
      checks++; if (o_ham !== eh) begin errors++; $display("FAIL dir%0d_ham got %h want %h", k, o_ham, eh); end
      stepN(1);
      checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_after got valid=%b ready=%b want 0/1", k, o_valid, o_ready); end
    end
  endtask

  task automatic test_random;
    logic [7:0] x, y, is, sd, ec, ed, eh;
    int cyc;
    bit seen;
    for (int k = 0; k < 24; k++) begin
      x  = 8'($urandom_range(0, 255));
      y  = 8'($urandom_range(0, 255));
      is = 8'($urandom_range(0, 255));
      sd = 8'($urandom_range(0, 255));
      if (k % 4 == 0) is = 8'($urandom_range(0, 15));
      if (k % 6 == 1) x = 8'($urandom_range(0, 1));
      model(int'(x), int'(y), int'(is), int'(sd), ec, ed, eh);
      sendWindow(x, y, is, sd);
      waitValid(1, cyc, seen);
      checks++; if (!seen || cyc != LAT) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", k, cyc, LAT); end
      checks++; if ({o_cov, o_dep, o_ham} !== {ec, ed, eh}) begin
        errors++; $display("FAIL rnd%0d_metrics x=%h y=%h is=%h got %h want %h", k, x, y, is, {o_cov, o_dep, o_ham}, {ec, ed, eh});
      end
      stepN(1 + $urandom_range(0, 3));
    end
  endtask

  task automatic test_drop;
    logic [7:0] ec, ed, eh;
    int cyc, pulses;
    bit seen;
    model(32'h60, 32'hA0, 32'h50, 32'h33, ec, ed, eh);
    sendWindow(8'h60, 8'hA0, 8'h50, 8'h33);
    stepN(DROP_AT - 1);
    i_countX = 8'hFF; i_countY = 8'h01; i_countIsect = 8'hF0; i_countSymdiff = 8'hAA;
    i_valid = 1'b1;
    stepN(1);
    i_valid = 1'b0;
    checks++; if (o_dropped !== 1'b1) begin errors++; $display("FAIL drop_set got %b want 1", o_dropped); end
    waitValid(DROP_AT + 1, cyc, seen);
    checks++; if (!seen || cyc != LAT) begin errors++; $display("FAIL drop_latency got %0d want %0d", cyc, LAT); end
    checks++; if ({o_cov, o_dep, o_ham} !== {ec, ed, eh}) begin errors++; $display("FAIL drop_first_result got %h want %h", {o_cov, o_dep, o_ham}, {ec, ed, eh}); end
    countPulses(LAT + 10, pulses);
    checks++; if (pulses != 0) begin errors++; $display("FAIL drop_no_second got %0d pulses want 0", pulses); end
    checks++; if (o_dropped !== 1'b1) begin errors++; $display("FAIL drop_sticky got %b want 1", o_dropped); end
    i_clearDropped = 1'b1;
    stepN(1);
    i_clearDropped = 1'b0;
    checks++; if (o_dropped !== 1'b0) begin errors++; $display("FAIL drop_clear got %b want 0", o_dropped); end
    sendWindow(8'h10, 8'h20, 8'h30, 8'h40);
    stepN(DROP_AT - 1);
    i_valid = 1'b1; i_clearDropped = 1'b1;
    stepN(1);
    i_valid = 1'b0; i_clearDropped = 1'b0;
    checks++; if (o_dropped !== 1'b1) begin errors++; $display("FAIL drop_set_wins got %b want 1", o_dropped); end
    waitValid(DROP_AT + 1, cyc, seen);
    stepN(2);
    i_clearDropped = 1'b1;
    stepN(1);
    i_clearDropped = 1'b0;
  endtask

  task automatic test_clock_gate;
    logic [7:0] ec, ed, eh;
    int cyc, pulses;
    bit seen;
    i_cg = 1'b0;
    sendWindow(8'h80, 8'h80, 8'h40, 8'h80);
    stepN(2);
    i_cg = 1'b1;
    countPulses(LAT + 5, pulses);
    checks++; if (pulses != 0 || o_ready !== 1'b1) begin errors++; $display("FAIL gate_idle_ignore got pulses=%0d ready=%b want 0/1", pulses, o_ready); end
    checks++; if (o_dropped !== 1'b0) begin errors++; $display("FAIL gate_idle_drop got %b want 0", o_dropped); end
    model(32'hC0, 32'h90, 32'h70, 32'h5A, ec, ed, eh);
    sendWindow(8'hC0, 8'h90, 8'h70, 8'h5A);
    stepN(GATE_AT - 1);
    i_cg = 1'b0;
    i_valid = 1'b1;
    pulses = 0;
    for (int g = 0; g < GATE_LEN; g++) begin
      stepN(1);
      i_valid = 1'b0;
      if (o_valid) pulses++;
    end
    i_cg = 1'b1;
    checks++; if (pulses != 0 || o_ready !== 1'b0) begin errors++; $display("FAIL gate_frozen got pulses=%0d ready=%b want 0/0", pulses, o_ready); end
    checks++; if (o_dropped !== 1'b0) begin errors++; $display("FAIL gate_no_drop got %b want 0", o_dropped); end
    waitValid(GATE_AT + GATE_LEN, cyc, seen);
    checks++; if (!seen || cyc != LAT + GATE_LEN) begin errors++; $display("FAIL gate_latency got %0d want %0d", cyc, LAT + GATE_LEN); end
    checks++; if ({o_cov, o_dep, o_ham} !== {ec, ed, eh}) begin errors++; $display("FAIL gate_result got %h want %h", {o_cov, o_dep, o_ham}, {ec, ed, eh}); end
    stepN(2);
  endtask

  task automatic test_reset_mid;
    int pulses;
    sendWindow(8'h80, 8'h80, 8'h80, 8'h77);
    stepN(RST_AT - 1);
    i_rst = 1'b1;
    stepN(1);
    i_rst = 1'b0;
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got ready=%b valid=%b want 1/0", o_ready, o_valid); end
    checks++; if ({o_cov, o_dep, o_ham} !== 24'h0) begin errors++; $display("FAIL rstmid_outputs got %h want 000000", {o_cov, o_dep, o_ham}); end
    countPulses(LAT + 10, pulses);
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_valid got %0d pulses want 0", pulses); end
  endtask

  initial begin
    i_rst = 1'b1; i_cg = 1'b1; i_valid = 1'b0; i_clearDropped = 1'b0;
    i_countX = 8'h00; i_countY = 8'h00; i_countIsect = 8'h00; i_countSymdiff = 8'h00;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_drop();
    test_clock_gate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
